// File: rtl/panel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : panel_sequencer_if
// Description : Debug-bus signal bundle between the front-panel sequencer
//               (master) and the target's debug port (slave). A single
//               request is outstanding at a time; the target completes it
//               with a one-cycle acknowledge strobe.
//   bus_req   master->slave  transaction request, held until ack/timeout
//   bus_we    master->slave  1 = write, 0 = read
//   bus_addr  master->slave  24-bit transaction address
//   bus_wdata master->slave  write data byte
//   bus_ack   slave->master  one-cycle completion strobe
//   bus_rdata slave->master  read data, valid with bus_ack on a read
// Revision    : 1.0 - initial release
// ============================================================================
interface panel_sequencer_if;
    logic        bus_req;
    logic        bus_we;
    logic [23:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/panel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : panel_sequencer
// Description : Front-panel command sequencer. Accumulates hex key entry,
//               executes load-address / examine / deposit / run / halt
//               commands and runs one request/acknowledge transaction at a
//               time on the debug bus. Drives the 24-bit panel display.
// Ports       :
//   clk, rst        clock, asynchronous active-high reset
//   key_valid/code  hex key strobe and value
//   fn_addr/exam/dep/run/halt  one-cycle function-key strobes
//   stopped         target halted (level)
//   dbg             debug bus (master modport)
//   run_req/halt_req  one-cycle pulses to the target controller
//   bus_err         one-cycle pulse on bus timeout
//   disp/disp_valid display value, low valid while a transaction is pending
// Revision    : 1.0 - initial release
// ============================================================================
module panel_sequencer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    input  logic                     fn_addr,
    input  logic                     fn_exam,
    input  logic                     fn_dep,
    input  logic                     fn_run,
    input  logic                     fn_halt,
    input  logic                     stopped,
    panel_sequencer_if.master        dbg,
    output logic                     run_req,
    output logic                     halt_req,
    output logic                     bus_err,
    output logic [23:0]              disp,
    output logic                     disp_valid
);

    // The counter only has to reach TIMEOUT-1: it reads 0 in the first
    // request cycle, so matching TIMEOUT-1 at an edge means TIMEOUT cycles
    // of bus_req have elapsed.
    localparam int unsigned          c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0]   c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    typedef enum logic {
        M_ENTRY = 1'b0,
        M_SHOW  = 1'b1
    } mode_t;

    state_t               r_state;
    state_t               w_state_nxt;
    mode_t                r_mode;

    logic [23:0]          r_ent;
    logic [23:0]          r_addr;
    logic [7:0]           r_wdata;
    logic [7:0]           r_data;
    logic                 r_stopped_d;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_run_req;
    logic                 r_halt_req;
    logic                 r_bus_err;

    logic                 w_idle;
    logic                 w_any_strobe;
    logic                 w_halt_pulse;
    logic                 w_run;
    logic                 w_ld_addr;
    logic                 w_exam;
    logic                 w_dep;
    logic                 w_key;
    logic                 w_refresh;
    logic                 w_ack;
    logic                 w_tmo;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Command decode and next-state logic. Strobes are resolved by fixed
    // priority first; a winner that is not allowed in the current
    // condition still suppresses every lower-priority strobe.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_idle       = (r_state == S_IDLE);
        w_any_strobe = fn_halt | fn_run | fn_addr | fn_exam | fn_dep | key_valid;

        w_halt_pulse = fn_halt & ~stopped;
        w_run        = ~fn_halt & fn_run & stopped & w_idle;
        w_ld_addr    = ~fn_halt & ~fn_run & fn_addr & stopped & w_idle;
        w_exam       = ~fn_halt & ~fn_run & ~fn_addr & fn_exam & stopped & w_idle;
        w_dep        = ~fn_halt & ~fn_run & ~fn_addr & ~fn_exam & fn_dep & stopped & w_idle;
        w_key        = ~fn_halt & ~fn_run & ~fn_addr & ~fn_exam & ~fn_dep & key_valid & w_idle;

        // Display refresh on the target stopping; any strobe in the same
        // cycle takes precedence and the refresh is lost.
        w_refresh    = stopped & ~r_stopped_d & ~w_any_strobe & w_idle;

        // Ack beats timeout when both land on the same edge.
        w_ack        = ~w_idle & dbg.bus_ack;
        w_tmo        = ~w_idle & ~dbg.bus_ack & (r_cnt == c_tmo_last);

        case (r_state)
            S_IDLE: begin
                if (w_ld_addr || w_exam || w_refresh) begin
                    w_state_nxt = S_RD;
                end else if (w_dep) begin
                    w_state_nxt = S_WR;
                end
            end
            S_RD, S_WR: begin
                if (w_ack || w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent       <= 24'd0;
            r_addr      <= 24'd0;
            r_wdata     <= 8'd0;
            r_data      <= 8'd0;
            r_mode      <= M_ENTRY;
            r_stopped_d <= 1'b0;
            r_cnt       <= '0;
            r_run_req   <= 1'b0;
            r_halt_req  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_stopped_d <= stopped;
            r_run_req   <= w_run;
            r_halt_req  <= w_halt_pulse;
            r_bus_err   <= w_tmo;

            // Idle holds the counter at zero, so it is already clear in
            // the first request cycle.
            if (w_idle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            if (w_key) begin
                r_ent  <= {r_ent[19:0], key_code};
                r_mode <= M_ENTRY;
            end

            if (w_ld_addr) begin
                r_addr <= r_ent;
                r_ent  <= 24'd0;
            end

            if (w_exam) begin
                r_addr <= r_addr + 24'd1;
            end

            if (w_dep) begin
                r_wdata <= r_ent[7:0];
                r_ent   <= 24'd0;
            end

            if (w_refresh) begin
                r_ent <= 24'd0;
            end

            if (w_ack) begin
                r_data <= (r_state == S_WR) ? r_wdata : dbg.bus_rdata;
                r_mode <= M_SHOW;
            end else if (w_tmo) begin
                r_data <= 8'hEE;
                r_mode <= M_SHOW;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Bus strobes decode directly from the state register so the
    // asynchronous reset removes bus_req without waiting for a clock.
    // ------------------------------------------------------------------
    assign dbg.bus_req   = (r_state != S_IDLE);
    assign dbg.bus_we    = (r_state == S_WR);
    assign dbg.bus_addr  = r_addr;
    assign dbg.bus_wdata = r_wdata;

    assign run_req    = r_run_req;
    assign halt_req   = r_halt_req;
    assign bus_err    = r_bus_err;
    assign disp       = (r_mode == M_SHOW) ? {r_addr[15:0], r_data} : r_ent;
    assign disp_valid = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_panel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_panel_sequencer
// Description : Self-checking bench for panel_sequencer. Keeps an
//               architectural model of the panel registers (entry, address,
//               write data, shown data, display mode) and compares the
//               display and debug-bus outputs against it after each step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_sequencer;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        fn_addr;
    logic        fn_exam;
    logic        fn_dep;
    logic        fn_run;
    logic        fn_halt;
    logic        stopped;
    logic        run_req;
    logic        halt_req;
    logic        bus_err;
    logic [23:0] disp;
    logic        disp_valid;

    panel_sequencer_if dbg ();

    panel_sequencer #(
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .fn_addr    (fn_addr),
        .fn_exam    (fn_exam),
        .fn_dep     (fn_dep),
        .fn_run     (fn_run),
        .fn_halt    (fn_halt),
        .stopped    (stopped),
        .dbg        (dbg),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .bus_err    (bus_err),
        .disp       (disp),
        .disp_valid (disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Architectural model
    logic [23:0] m_ent;
    logic [23:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_data;
    bit          m_show;

    function automatic logic [23:0] exp_disp();
        return m_show ? {m_addr[15:0], m_data} : m_ent;
    endfunction

    task automatic model_reset();
        m_ent   = 24'd0;
        m_addr  = 24'd0;
        m_wdata = 8'd0;
        m_data  = 8'd0;
        m_show  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the edge that launched a transaction. Holds off the
    // ack for lat cycles (throwing in keys that must be dropped), then acks.
    task automatic wait_txn(input bit we, input int lat, input logic [7:0] rd);
        chk("bus_req_on", dbg.bus_req, 1);
        chk("disp_valid_busy", disp_valid, 0);
        chk("bus_we", dbg.bus_we, we);
        chk("bus_addr", dbg.bus_addr, m_addr);
        if (we) chk("bus_wdata", dbg.bus_wdata, m_wdata);
        for (int i = 0; i < lat; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 4'($urandom);
            tick();
            key_valid = 1'b0;
            chk("bus_req_hold", dbg.bus_req, 1);
        end
        dbg.bus_ack   = 1'b1;
        dbg.bus_rdata = rd;
        tick();
        dbg.bus_ack   = 1'b0;
        dbg.bus_rdata = 8'($urandom);
        m_data = we ? m_wdata : rd;
        m_show = 1'b1;
        chk("bus_req_off", dbg.bus_req, 0);
        chk("disp_valid_done", disp_valid, 1);
        chk("bus_err_quiet", bus_err, 0);
        chk("disp_done", disp, exp_disp());
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        m_ent  = {m_ent[19:0], k};
        m_show = 1'b0;
        chk("disp_entry", disp, exp_disp());
    endtask

    task automatic cmd_addr(input int lat, input logic [7:0] rd);
        fn_addr   = 1'b1;
        key_valid = 1'($urandom_range(0, 1));
        key_code  = 4'($urandom);
        tick();
        fn_addr   = 1'b0;
        key_valid = 1'b0;
        m_addr = m_ent;
        m_ent  = 24'd0;
        wait_txn(1'b0, lat, rd);
    endtask

    task automatic cmd_exam(input int lat, input logic [7:0] rd);
        fn_exam = 1'b1;
        fn_dep  = 1'($urandom_range(0, 1));
        tick();
        fn_exam = 1'b0;
        fn_dep  = 1'b0;
        m_addr = m_addr + 24'd1;
        wait_txn(1'b0, lat, rd);
    endtask

    task automatic cmd_dep(input int lat);
        fn_dep = 1'b1;
        tick();
        fn_dep = 1'b0;
        m_wdata = m_ent[7:0];
        m_ent   = 24'd0;
        wait_txn(1'b1, lat, 8'($urandom));
    endtask

    int cyc;
    int errs;
    int op;

    initial begin
        rst           = 1'b1;
        stopped       = 1'b1;
        key_valid     = 1'b0;
        key_code      = 4'd0;
        fn_addr       = 1'b0;
        fn_exam       = 1'b0;
        fn_dep        = 1'b0;
        fn_run        = 1'b0;
        fn_halt       = 1'b0;
        dbg.bus_ack   = 1'b0;
        dbg.bus_rdata = 8'd0;
        model_reset();

        // Reset state
        repeat (2) tick();
        chk("rst_bus_req", dbg.bus_req, 0);
        chk("rst_bus_we", dbg.bus_we, 0);
        chk("rst_bus_addr", dbg.bus_addr, 0);
        chk("rst_bus_wdata", dbg.bus_wdata, 0);
        chk("rst_run_req", run_req, 0);
        chk("rst_halt_req", halt_req, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_disp", disp, 0);
        chk("rst_disp_valid", disp_valid, 1);

        // Release with stopped=1: refresh read at address 0
        rst = 1'b0;
        tick();
        m_ent = 24'd0;
        wait_txn(1'b0, 1, 8'h5A);

        // Keys 1..6, load address, 1-cycle ack of 0xA5
        for (int k = 1; k <= 6; k++) press(4'(k));
        chk("entry_123456", disp, 24'h123456);
        cmd_addr(0, 8'hA5);
        chk("show_3456A5", disp, 24'h3456A5);

        // Examine across the top of the address space
        for (int k = 0; k < 6; k++) press(4'hF);
        cmd_addr(2, 8'($urandom));
        cmd_exam(0, 8'h3C);
        chk("exam_wrap_disp", disp, 24'h00003C);

        // Deposit 0x7F at the unchanged address, then confirm entry cleared
        press(4'h7);
        press(4'hF);
        cmd_dep(1);
        chk("dep_disp", disp, 24'h00007F);
        press(4'h9);
        chk("ent_cleared", disp, 24'h000009);

        // Timeout: target never acks
        fn_exam = 1'b1;
        tick();
        fn_exam = 1'b0;
        m_addr = m_addr + 24'd1;
        chk("tmo_bus_addr", dbg.bus_addr, m_addr);
        cyc  = 0;
        errs = 0;
        while (dbg.bus_req && cyc < 50) begin
            cyc++;
            tick();
            if (bus_err) errs++;
        end
        tick();
        if (bus_err) errs++;
        m_data = 8'hEE;
        m_show = 1'b1;
        chk("tmo_req_cycles", cyc, 8);
        chk("tmo_err_pulses", errs, 1);
        chk("tmo_disp_low", disp[7:0], 8'hEE);
        chk("tmo_disp", disp, exp_disp());
        chk("tmo_disp_valid", disp_valid, 1);

        // Target running: only halt has an effect
        stopped = 1'b0;
        tick();
        fn_addr = 1'b1;
        tick();
        fn_addr = 1'b0;
        chk("run_addr_ignored", dbg.bus_req, 0);
        fn_exam = 1'b1;
        tick();
        fn_exam = 1'b0;
        chk("run_exam_ignored", dbg.bus_req, 0);
        fn_run = 1'b1;
        tick();
        fn_run = 1'b0;
        chk("run_run_ignored", run_req, 0);
        chk("run_run_no_req", dbg.bus_req, 0);
        fn_halt = 1'b1;
        tick();
        fn_halt = 1'b0;
        chk("halt_pulse", halt_req, 1);
        tick();
        chk("halt_pulse_end", halt_req, 0);
        chk("running_disp", disp, exp_disp());

        // Target stops: refresh read at the current address
        stopped = 1'b1;
        tick();
        m_ent = 24'd0;
        wait_txn(1'b0, 2, 8'($urandom));

        // fn_run beats a key in the same cycle
        press(4'h3);
        fn_run    = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h5;
        tick();
        fn_run    = 1'b0;
        key_valid = 1'b0;
        chk("run_pulse", run_req, 1);
        chk("run_no_bus", dbg.bus_req, 0);
        tick();
        chk("run_pulse_end", run_req, 0);
        chk("run_key_dropped", disp, 24'h000003);

        // Randomised command mix against the model
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 8));
            case (op)
                0, 1, 2: press(4'($urandom));
                3:       cmd_addr(int'($urandom_range(0, 7)), 8'($urandom));
                4:       cmd_exam(int'($urandom_range(0, 7)), 8'($urandom));
                5:       cmd_dep(int'($urandom_range(0, 7)));
                6: begin
                    fn_halt = 1'b1;
                    fn_addr = 1'($urandom_range(0, 1));
                    tick();
                    fn_halt = 1'b0;
                    fn_addr = 1'b0;
                    chk("rnd_halt_stopped", halt_req, 0);
                    chk("rnd_halt_no_bus", dbg.bus_req, 0);
                    chk("rnd_halt_disp", disp, exp_disp());
                end
                7: begin
                    fn_run    = 1'b1;
                    key_valid = 1'($urandom_range(0, 1));
                    key_code  = 4'($urandom);
                    tick();
                    fn_run    = 1'b0;
                    key_valid = 1'b0;
                    chk("rnd_run_pulse", run_req, 1);
                    chk("rnd_run_no_bus", dbg.bus_req, 0);
                    chk("rnd_run_disp", disp, exp_disp());
                end
                default: begin
                    dbg.bus_ack   = 1'b1;
                    dbg.bus_rdata = 8'($urandom);
                    tick();
                    dbg.bus_ack   = 1'b0;
                    chk("rnd_idle_ack_req", dbg.bus_req, 0);
                    chk("rnd_idle_ack_disp", disp, exp_disp());
                end
            endcase
        end

        // Reset in the middle of a transaction
        press(4'h2);
        fn_addr = 1'b1;
        tick();
        fn_addr = 1'b0;
        chk("pre_rst_req", dbg.bus_req, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_req", dbg.bus_req, 0);
        chk("async_rst_disp", disp, 0);
        chk("async_rst_dv", disp_valid, 1);
        tick();
        rst = 1'b0;
        tick();
        wait_txn(1'b0, 0, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/panel_sequencer.md
# panel_sequencer

Front-panel command sequencer between the decoded keypad and the target's debug bus. It accumulates hex key entry, executes load-address, examine, deposit, run and halt commands, and runs a single-outstanding request/acknowledge transaction on the debug bus. It drives the 24-bit panel display with either the entry in progress or the last addressed location and its data.

## Interface
Parameters:
- TIMEOUT, 1023: bus wait limit in cycles; a value of 1 or more is required.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; a hex key was pressed.
- key_code  in  4  key value, 0x0-0xF. Valid only with key_valid.
- fn_addr  in  1  one-cycle strobe: load address from entry.
- fn_exam  in  1  one-cycle strobe: examine next location.
- fn_dep  in  1  one-cycle strobe: deposit entry byte.
- fn_run  in  1  one-cycle strobe: request run.
- fn_halt  in  1  one-cycle strobe: request halt.
- stopped  in  1  target halted, level.
- bus_req  out  1  transaction request. Held until ack or timeout.
- bus_we  out  1  1 = write, 0 = read. Stable while bus_req is high.
- bus_addr  out  24  transaction address. Equals the addr register.
- bus_wdata  out  8  write data.
- bus_ack  in  1  one-cycle completion strobe from the target.
- bus_rdata  in  8  read data. Valid with bus_ack on a read.
- run_req  out  1  one-cycle pulse to the target controller.
- halt_req  out  1  one-cycle pulse to the target controller.
- bus_err  out  1  one-cycle pulse on timeout.
- disp  out  24  display value.
- disp_valid  out  1  low while a transaction is pending.

## Operation
- Registers:
  - ent[23:0]: entry register.
  - addr[23:0]: current address.
  - wdata[7:0]: write data.
  - data[7:0]: last read or written byte.
  - mode: either ENTRY or SHOW.
- State machine:
  - States are IDLE, RD, WR.
  - RD and WR both hold bus_req=1. bus_we=0 in RD and 1 in WR.
  - Either state returns to IDLE on the cycle bus_ack=1, or when the timeout counter reaches TIMEOUT.
- Key entry, IDLE only:
  - ent <= {ent[19:0], key_code}.
  - mode <= ENTRY.
  - key_valid is ignored in RD and WR; the key is dropped.
- Command priority when several strobes arrive in one cycle: fn_halt > fn_run > fn_addr > fn_exam > fn_dep > key_valid. Only the winner takes effect; the rest are dropped.
- fn_halt: pulses halt_req only if stopped=0. Accepted in any state.
- fn_run: pulses run_req only if stopped=1 and the state is IDLE.
- fn_addr, fn_exam and fn_dep act only when stopped=1 and the state is IDLE. Otherwise they are ignored.
  - fn_addr: addr <= ent; ent <= 0; go to RD.
  - fn_exam: addr <= addr + 1, modulo 2^24 so 0xFFFFFF wraps to 0x000000; go to RD.
  - fn_dep: wdata <= ent[7:0]; ent <= 0; go to WR. addr is unchanged.
- Read completion: data <= bus_rdata; mode <= SHOW.
- Write completion: data <= wdata; mode <= SHOW.
- Timeout:
  - bus_req drops.
  - bus_err pulses for one cycle.
  - data <= 0xEE; mode <= SHOW.
  - addr is unchanged.
- Rising edge of stopped (registered edge detect): clear ent, then go to RD at the current addr to refresh the display. If a strobe arrives in the same cycle, the strobe wins and the refresh is dropped.
- Falling edge of stopped during RD or WR: the transaction runs to completion or timeout.
- disp output:
  - In ENTRY mode: disp = ent.
  - In SHOW mode: disp = {addr[15:0], data}.
  - disp_valid = (state == IDLE).
- Reset values:
  - state=IDLE, mode=ENTRY.
  - ent, addr, wdata and data = 0.
  - bus_req, bus_we, run_req, halt_req and bus_err = 0.
  - bus_addr=0, bus_wdata=0, disp=0, disp_valid=1.
  - The stopped edge-detect register resets to 0, so stopped=1 at reset release produces a refresh read.

## Timing
- A command sampled at edge N gives bus_req=1 and disp_valid=0 after edge N. bus_addr and bus_we are valid in the same cycle.
- bus_ack sampled high at edge M gives, after edge M:
  - bus_req=0 and state IDLE;
  - disp updated and disp_valid=1.
- Fastest case: ack in the first request cycle gives a 2-cycle command-to-display latency.
- The next command is accepted from edge M+1.
- A bus_ack arriving while in IDLE is ignored.
- The timeout counter clears on entry to RD or WR. It times out after TIMEOUT cycles of bus_req with no ack. If ack and timeout coincide, the ack wins.
- run_req, halt_req and bus_err are registered one-cycle pulses, asserted the cycle after the causing edge.
- Assertion of rst forces all reset values immediately, including mid-transaction; bus_req drops asynchronously.

## Test plan
- Keys 1,2,3,4,5,6, then fn_addr with stopped=1, target returns 0xA5 with 1-cycle ack:
  - disp goes 0x000001 through 0x123456;
  - bus read at 0x123456;
  - disp = 0x3456A5.
- With addr=0xFFFFFF, fn_exam, ack with 0x3C: bus_addr=0x000000 and disp=0x00003C.
- Keys 7,F then fn_dep:
  - bus_we=1 and bus_wdata=0x7F at the unchanged addr;
  - after ack, disp = {addr[15:0], 0x7F} and ent=0.
- Target never acks, TIMEOUT=8:
  - bus_req high for exactly 8 cycles;
  - bus_err pulses once;
  - disp low byte = 0xEE.
- stopped=0 with fn_addr, fn_exam and fn_run: no bus_req and no run_req. fn_halt pulses halt_req. Raising stopped then triggers a refresh read at the current addr.
- fn_run and a key strobe in the same cycle with stopped=1: only run_req pulses and ent is unchanged. rst asserted while bus_req=1: bus_req=0 immediately and disp=0.
